fetch_pc_unit: RTL
==================

# fetch_pc_unit

Fetch-stage program-counter generator for the pipelined core. It holds the fetch PC, drives the BTB lookup address each cycle, and consumes the BTB's hit, prediction and target outputs to choose the next PC. It also applies stalls from the hazard unit and mispredict redirects from EX. It hands the fetch PC and its prediction metadata to the IF/ID register, which carries them to EX for resolution.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `stall`  in  1: hazard unit hold; PC frozen.
- `redirect_en`  in  1: EX mispredict or resolved-jump redirect.
- `redirect_pc`  in  32: corrected fetch address.
- `btb_hit`  in  1: BTB hit for `btb_pc_lookup`.
- `btb_predict_taken`  in  1: BTB predicted direction.
- `btb_target`  in  32: BTB predicted target.
- `btb_pc_lookup`  out  32: equals `pc_f`.
- `pc_f`  out  32: current fetch PC.
- `pc_plus4_f`  out  32: `pc_f + 4`.
- `fetch_valid`  out  1: `pc_f` is a real fetch; 0 during the boot bubble.
- `pred_taken_f`  out  1: `fetch_valid & btb_hit & btb_predict_taken`.
- `pred_target_f`  out  32: `btb_target` when `pred_taken_f`, else `pc_plus4_f`.
- `misalign_err`  out  1: sticky; set by a redirect with `redirect_pc[1:0] != 0`.
- `redirect_cnt`  out  32: redirects accepted (performance counter).
- `pred_taken_cnt`  out  32: fetches predicted taken (performance counter).

## Operation
- FSM with two states, BOOT and RUN.
  - Reset enters BOOT.
  - BOOT: `fetch_valid = 0` and the PC holds. The next clock goes to RUN unconditionally.
  - RUN: `fetch_valid = 1`. The FSM leaves RUN only on `rst`.
- Next-PC priority, evaluated in RUN:
  1. `redirect_en`: next PC = `{redirect_pc[31:2], 2'b00}`. Redirect beats `stall`.
  2. `stall`: hold `pc_f`.
  3. `pred_taken_f`: next PC = `{btb_target[31:2], 2'b00}`.
  4. Otherwise: next PC = `pc_plus4_f`.
- A `redirect_en` pulse received in BOOT is applied and the FSM still moves to RUN.
- `misalign_err` sets when `redirect_en` is accepted with `redirect_pc[1:0] != 0`. Only `rst` clears it.
- Arithmetic:
  - All PC sums are 32-bit modulo.
  - `32'hFFFF_FFFC + 4` wraps to 0 with no flag.
- Lookup path:
  - `btb_pc_lookup` is combinational from the `pc_f` register.
  - The prediction outputs are combinational from the BTB outputs.
  - The unit never writes the BTB.
- Stall with a BTB hit: the PC holds. `pred_taken_f` and `pred_target_f` stay asserted for the held PC and are consistent with it.
- Simultaneous `redirect_en` and `pred_taken_f`: the redirect wins and the prediction is discarded.
- Reset mid-operation: everything returns to its reset state asynchronously. Counters clear.

## Timing
- Reset values:
  - `pc_f = RESET_PC`, `pc_plus4_f = RESET_PC + 4`.
  - `fetch_valid = 0`, `misalign_err = 0`.
  - Counters 0. State BOOT.
- `pred_taken_f` is 0 during reset because `fetch_valid = 0`.
- The PC updates on the rising edge. The first valid fetch at `RESET_PC` occurs in the cycle after the first edge following `rst` deassertion.
- Redirect latency is one cycle: `redirect_en` in cycle N gives `pc_f = redirect_pc` in cycle N+1.
- A predicted-taken fetch in cycle N gives `pc_f = btb_target` in cycle N+1, with zero bubbles.
- `redirect_en` is a single-cycle pulse. Each asserted cycle counts as a separate redirect.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- Defined:
  - `redirect_cnt` increments on every accepted redirect.
  - `pred_taken_cnt` increments on every cycle with `pred_taken_f & ~stall & ~redirect_en`.
  - Both are 32-bit, saturating at 32'hFFFF_FFFF, and cleared by `rst`.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Reset with `RESET_PC = 32'h0000_1000`, no BTB hits, release `rst`:
  - One cycle with `fetch_valid = 0` at 0x1000.
  - Then `pc_f` = 0x1000, 0x1004, 0x1008 on consecutive cycles.
- BTB hit, predict taken, target 0x2000, at `pc_f = 0x1008`:
  - Next cycle `pc_f = 0x2000`.
  - `pred_taken_f = 1` and `pred_target_f = 0x2000` in the hit cycle.
- `stall = 1` for 3 cycles at 0x1004 with `redirect_en` asserted in the 2nd cycle, `redirect_pc = 0x3000`:
  - PC holds for 1 cycle, then `pc_f = 0x3000`.
  - `redirect_cnt = 1` when `FETCH_PERF_CNT_EN` is defined.
- Redirect to 0x3006:
  - `pc_f = 0x3004`.
  - `misalign_err = 1`, and it stays 1 until `rst`.
- `redirect_en` and a taken BTB hit in the same cycle: redirect target taken and `pred_taken_cnt` unchanged.
- `pc_f = 0xFFFF_FFFC`, no hit: next `pc_f = 0`. Assert `rst` mid-run: `pc_f = RESET_PC` and counters 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Signal bundle between the fetch PC generator and its environment
// (hazard unit, EX redirect, BTB lookup port, IF/ID register).
interface fetch_pc_unit_if;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        btb_hit;
    logic        btb_predict_taken;
    logic [31:0] btb_target;
    logic [31:0] btb_pc_lookup;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        fetch_valid;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        misalign_err;
    logic [31:0] redirect_cnt;
    logic [31:0] pred_taken_cnt;

    // Environment side: drives control and BTB results, observes the fetch PC.
    modport master (
        output stall, redirect_en, redirect_pc,
        output btb_hit, btb_predict_taken, btb_target,
        input  btb_pc_lookup, pc_f, pc_plus4_f, fetch_valid,
        input  pred_taken_f, pred_target_f, misalign_err,
        input  redirect_cnt, pred_taken_cnt
    );

    // Fetch PC unit side.
    modport slave (
        input  stall, redirect_en, redirect_pc,
        input  btb_hit, btb_predict_taken, btb_target,
        output btb_pc_lookup, pc_f, pc_plus4_f, fetch_valid,
        output pred_taken_f, pred_target_f, misalign_err,
        output redirect_cnt, pred_taken_cnt
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with BTB-driven prediction and EX redirects.
// Optional saturating performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_unit_if.slave bus
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_s;
    logic        fetch_valid_s;
    logic        pred_taken_s;
    logic        misalign_q;
    logic        misalign_d;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign pc_plus4_s   = pc_q + 32'd4;
    assign pred_taken_s = fetch_valid_s & bus.btb_hit & bus.btb_predict_taken;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and fetch-valid decode
    always_comb begin
        state_d       = state_q;
        fetch_valid_s = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                fetch_valid_s = 1'b0;
            end
            ST_RUN: begin
                state_d       = ST_RUN;
                fetch_valid_s = 1'b1;
            end
            default: begin
                state_d       = ST_BOOT;
                fetch_valid_s = 1'b0;
            end
        endcase
    end

    // Next-PC selection; a redirect is honoured even in the boot bubble
    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_en) begin
            pc_d = word_align(bus.redirect_pc);
        end else if (!fetch_valid_s) begin
            pc_d = pc_q;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (pred_taken_s) begin
            pc_d = word_align(bus.btb_target);
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // Sticky misaligned-redirect flag
    always_comb begin
        misalign_d = misalign_q;
        if (bus.redirect_en && (bus.redirect_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end else begin
            misalign_d = misalign_q;
        end
    end

    // PC and error flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] pred_cnt_q;
    logic        pred_cnt_inc_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : (val + 32'd1);
    endfunction

    // Only predictions that actually steer the PC are counted
    assign pred_cnt_inc_s = pred_taken_s & ~bus.stall & ~bus.redirect_en;

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= 32'd0;
            pred_cnt_q     <= 32'd0;
        end else begin
            if (bus.redirect_en) begin
                redirect_cnt_q <= sat_inc(redirect_cnt_q);
            end
            if (pred_cnt_inc_s) begin
                pred_cnt_q <= sat_inc(pred_cnt_q);
            end
        end
    end

    assign bus.redirect_cnt   = redirect_cnt_q;
    assign bus.pred_taken_cnt = pred_cnt_q;
`else
    assign bus.redirect_cnt   = 32'd0;
    assign bus.pred_taken_cnt = 32'd0;
`endif

    assign bus.btb_pc_lookup = pc_q;
    assign bus.pc_f          = pc_q;
    assign bus.pc_plus4_f    = pc_plus4_s;
    assign bus.fetch_valid   = fetch_valid_s;
    assign bus.pred_taken_f  = pred_taken_s;
    assign bus.pred_target_f = pred_taken_s ? bus.btb_target : pc_plus4_s;
    assign bus.misalign_err  = misalign_q;

endmodule
